cpri_tx_pingpong_buf: RTL

CPRI_TX_PINGPONG_BUF -- requirements
Module: cpri_tx_pingpong_buf

---
 rtl/cpri_tx_pingpong_buf_if.sv | 28 ++
 rtl/cpri_tx_pingpong_buf.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cpri_tx_pingpong_buf_if.sv
// Write-side and stream-side signal bundle for the CPRI TX ping-pong buffer.
// Signal names keep the i_/o_ prefixes as seen from the buffer.
interface cpri_tx_pingpong_buf_if #(
    parameter int unsigned DW = 64
);
    logic          i_cpri_wen;
    logic [6:0]    i_cpri_waddr;
    logic [DW-1:0] i_cpri_wdata;
    logic          i_cpri_wlast;
    logic          i_tx_ready;
    logic          o_tx_valid;
    logic [DW-1:0] o_tx_data;
    logic          o_tx_sop;
    logic          o_tx_eop;
    logic [1:0]    o_bank_full;
    logic          o_drop_pulse;
    logic [15:0]   o_drop_cnt;

    modport master (
        output i_cpri_wen, i_cpri_waddr, i_cpri_wdata, i_cpri_wlast, i_tx_ready,
        input  o_tx_valid, o_tx_data, o_tx_sop, o_tx_eop, o_bank_full, o_drop_pulse, o_drop_cnt
    );

    modport slave (
        input  i_cpri_wen, i_cpri_waddr, i_cpri_wdata, i_cpri_wlast, i_tx_ready,
        output o_tx_valid, o_tx_data, o_tx_sop, o_tx_eop, o_bank_full, o_drop_pulse, o_drop_cnt
    );
endinterface

// File: rtl/cpri_tx_pingpong_buf.sv
// Two-bank frame buffer between the CPRI TX generator and a ready/valid stream.
// Writer fills one bank while the reader drains the other; frames aimed at a full bank are dropped.
module cpri_tx_pingpong_buf #(
    parameter int unsigned DW    = 64,
    parameter int unsigned DEPTH = 96
) (
    input  logic                      clk,
    input  logic                      rst,
    cpri_tx_pingpong_buf_if.slave     bus
);

    localparam logic [7:0] DepthW = 8'(DEPTH);
    localparam logic [6:0] LastA  = 7'(DEPTH - 1);

    typedef enum logic {StIdle, StStream} state_e;

    logic [DW-1:0] mem [2][DEPTH];

    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic          drop_q, drop_d;
    logic [1:0]    full_q, full_d;
    logic          pulse_q, pulse_d;
    logic [15:0]   cnt_q, cnt_d;
    state_e        state_q, state_d;
    logic [6:0]    rd_addr_q, rd_addr_d;
    logic          valid_q, valid_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;
    logic [DW-1:0] data_q, data_d;

    logic drop_now, addr_ok, wr_en, set_full, clr_full;

    // Writer: the drop decision is re-taken at every word 0 and latched for the rest of the frame.
    always_comb begin
        drop_now  = (bus.i_cpri_waddr == 7'd0) ? full_q[wr_bank_q] : drop_q;
        addr_ok   = ({1'b0, bus.i_cpri_waddr} < DepthW);
        wr_en     = bus.i_cpri_wen && !drop_now && addr_ok && !rst;
        set_full  = bus.i_cpri_wen && bus.i_cpri_wlast && !drop_now;
        drop_d    = drop_q;
        wr_bank_d = wr_bank_q;
        pulse_d   = 1'b0;
        cnt_d     = cnt_q;
        if (bus.i_cpri_wen) begin
            if (bus.i_cpri_wlast) begin
                drop_d = 1'b0;
                if (drop_now) begin
                    pulse_d = 1'b1;
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                end else begin
                    wr_bank_d = ~wr_bank_q;
                end
            end else begin
                drop_d = drop_now;
            end
        end
    end

    // Reader FSM: outputs are registered, so a stall simply keeps the current word.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_bank_d = rd_bank_q;
        valid_d   = valid_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        data_d    = data_q;
        clr_full  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (full_q[rd_bank_q]) begin
                    data_d    = mem[rd_bank_q][0];
                    valid_d   = 1'b1;
                    sop_d     = 1'b1;
                    eop_d     = (DEPTH == 1);
                    rd_addr_d = 7'd1;
                    state_d   = StStream;
                end
            end
            StStream: begin
                if (valid_q && bus.i_tx_ready) begin
                    if (!eop_q) begin
                        data_d    = mem[rd_bank_q][rd_addr_q];
                        sop_d     = 1'b0;
                        eop_d     = (rd_addr_q == LastA);
                        rd_addr_d = rd_addr_q + 7'd1;
                    end else begin
                        valid_d   = 1'b0;
                        sop_d     = 1'b0;
                        eop_d     = 1'b0;
                        clr_full  = 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Set and clear always address different banks, so both can apply together.
    always_comb begin
        full_d = full_q;
        if (set_full) full_d[wr_bank_q] = 1'b1;
        if (clr_full) full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            drop_q    <= 1'b0;
            full_q    <= 2'b00;
            pulse_q   <= 1'b0;
            cnt_q     <= 16'd0;
            state_q   <= StIdle;
            rd_addr_q <= 7'd0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            drop_q    <= drop_d;
            full_q    <= full_d;
            pulse_q   <= pulse_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            valid_q   <= valid_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            data_q    <= data_d;
        end
    end

    // Storage is deliberately not reset; short frames expose stale words.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank_q][bus.i_cpri_waddr] <= bus.i_cpri_wdata;
    end

    assign bus.o_tx_valid   = valid_q;
    assign bus.o_tx_data    = data_q;
    assign bus.o_tx_sop     = sop_q;
    assign bus.o_tx_eop     = eop_q;
    assign bus.o_bank_full  = full_q;
    assign bus.o_drop_pulse = pulse_q;
    assign bus.o_drop_cnt   = cnt_q;

endmodule
